cache_debug_sweep: RTL and testbench

//  Sequencer that walks a range of cache line indices over one or more cache debug ports.

---
 rtl/cache_debug_sweep_pkg.sv | 37 +++
 rtl/cache_debug_sweep_pick.sv | 24 ++
 rtl/cache_debug_sweep.sv | 237 +++++++++++++++++++++++
 tb/tb_cache_debug_sweep.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_debug_sweep_pkg.sv
// Shared types for the cache debug sweep: line index/address layout, debug port map, sweep states.
package cache_debug_sweep_pkg;

  localparam int INDEX_W  = 6;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = 32 - 1 - INDEX_W - OFFSET_W;

  typedef logic [INDEX_W-1:0] addr_index;
  typedef logic [31:0]        word;

  typedef struct packed {
    logic              io;
    logic [TAG_W-1:0]  tag;
    addr_index         index;
    logic [OFFSET_W-1:0] offset;
  } addr_bits;

  localparam logic [2:0] DBG_ADDR_STATUS = 3'd0;
  localparam logic [2:0] DBG_ADDR_WORD0  = 3'd4;
  localparam int         DBG_LINE_WORDS  = 5;

  typedef enum logic [2:0] {
    IDLE,
    PICK,
    LOAD,
    READ,
    PUSH,
    NEXT,
    DONE
  } sweep_state;

  // Word k of a dumped line: k=0 is the status word, k=1..4 map to data words 0..3.
  function automatic logic [2:0] word_addr(input logic [2:0] k);
    return (k == 3'd0) ? DBG_ADDR_STATUS : (DBG_ADDR_WORD0 + k - 3'd1);
  endfunction

endpackage

// File: rtl/cache_debug_sweep_pick.sv
// Lowest set mask bit at or above pos; found=0 when none remain.
// Purely combinational, no handshake.
module cache_sweep_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] mask,
  input  logic [3:0]   pos,
  output logic         found,
  output logic [2:0]   idx
);

  // Scan downwards so the lowest qualifying bit is the one left standing.
  always_comb begin
    found = 1'b0;
    idx   = 3'd0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (4'(i) >= pos)) begin
        found = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/cache_debug_sweep.sv
// Walks line indices over the masked caches, streaming status + 4 data words per line.
// Registered outputs, one bus transaction per word; waitrequest and out_ready stall the walk in place.
module cache_debug_sweep
  import cache_debug_sweep_pkg::*;
#(
  parameter int NUM_CACHES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ctrl_start,
  input  logic                  ctrl_abort,
  input  addr_index             ctrl_first,
  input  addr_index             ctrl_last,
  input  logic [NUM_CACHES-1:0] ctrl_mask,
  output logic                  ctrl_busy,
  output logic                  ctrl_done,
  output logic                  ctrl_aborted,
  output logic [15:0]           ctrl_count,
  output logic [NUM_CACHES-1:0] dbg_select,
  output logic [2:0]            dbg_address,
  output logic                  dbg_read,
  output logic                  dbg_write,
  output word                   dbg_writedata,
  input  logic                  dbg_waitrequest,
  input  word                   dbg_readdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output word                   out_data,
  output logic [2:0]            out_cache,
  output logic                  out_last
);

  localparam logic [2:0] LAST_K = 3'(DBG_LINE_WORDS - 1);

  sweep_state            state_q, state_d;
  addr_index             last_q, last_d;
  addr_index             cur_idx_q, cur_idx_d;
  logic [NUM_CACHES-1:0] mask_q, mask_d;
  logic [2:0]            cur_cache_q, cur_cache_d;
  logic                  cache_vld_q, cache_vld_d;
  logic [2:0]            k_q, k_d;
  logic                  abort_pend_q, abort_pend_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic [15:0]           count_q, count_d;
  logic [NUM_CACHES-1:0] select_q, select_d;
  logic [2:0]            address_q, address_d;
  logic                  read_q, read_d;
  logic                  write_q, write_d;
  word                   writedata_q, writedata_d;
  logic                  out_valid_q, out_valid_d;
  word                   out_data_q, out_data_d;
  logic [2:0]            out_cache_q, out_cache_d;
  logic                  out_last_q, out_last_d;

  logic       pick_found;
  logic [2:0] pick_idx;
  logic [3:0] pick_pos;
  logic       abort_hit;
  addr_bits   load_bits;

  // cache_vld_q=0 stands for "no cache visited yet at this index".
  assign pick_pos = cache_vld_q ? ({1'b0, cur_cache_q} + 4'd1) : 4'd0;

  cache_sweep_pick #(.N(NUM_CACHES)) u_pick (
    .mask  (mask_q),
    .pos   (pick_pos),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    mask_d       = mask_q;
    cur_idx_d    = cur_idx_q;
    cur_cache_d  = cur_cache_q;
    cache_vld_d  = cache_vld_q;
    k_d          = k_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;
    count_d      = count_q;
    out_data_d   = out_data_q;
    out_cache_d  = out_cache_q;
    out_last_d   = out_last_q;
    abort_hit    = abort_pend_q | ctrl_abort;

    case (state_q)
      IDLE: begin
        if (ctrl_start) begin
          last_d      = ctrl_last;
          mask_d      = ctrl_mask;
          cur_idx_d   = ctrl_first;
          cache_vld_d = 1'b0;
          count_d     = 16'd0;
          aborted_d   = 1'b0;
          state_d     = PICK;
        end
      end
      PICK: begin
        if (mask_q == '0) begin
          state_d = DONE;
        end else if (pick_found) begin
          cur_cache_d = pick_idx;
          cache_vld_d = 1'b1;
          state_d     = LOAD;
        end else begin
          state_d = NEXT;
        end
      end
      LOAD: begin
        if (!dbg_waitrequest) begin
          k_d     = 3'd0;
          state_d = READ;
        end
      end
      READ: begin
        if (!dbg_waitrequest) begin
          out_data_d  = dbg_readdata;
          out_cache_d = cur_cache_q;
          out_last_d  = (k_q == LAST_K);
          state_d     = PUSH;
        end
      end
      PUSH: begin
        if (out_ready) begin
          if (k_q == LAST_K) begin
            count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            state_d = PICK;
          end else begin
            k_d     = k_q + 3'd1;
            state_d = READ;
          end
        end
      end
      NEXT: begin
        if (cur_idx_q == last_q) begin
          state_d = DONE;
        end else begin
          cur_idx_d   = cur_idx_q + INDEX_W'(1);
          cache_vld_d = 1'b0;
          state_d     = PICK;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A pending abort only takes effect when a state is left, so bus and stream handshakes finish first.
    if (state_q inside {PICK, LOAD, READ, PUSH, NEXT}) begin
      abort_pend_d = abort_hit;
      if (abort_hit && (state_d != state_q)) begin
        state_d      = DONE;
        aborted_d    = 1'b1;
        abort_pend_d = 1'b0;
      end
    end else begin
      abort_pend_d = 1'b0;
    end

    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    read_d      = (state_d == READ);
    write_d     = (state_d == LOAD);
    out_valid_d = (state_d == PUSH);
    select_d    = (read_d || write_d) ? (NUM_CACHES'(1) << cur_cache_d) : '0;
    address_d   = read_d ? word_addr(k_d) : DBG_ADDR_STATUS;

    load_bits       = '0;
    load_bits.index = cur_idx_d;
    writedata_d     = write_d ? word'(load_bits) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_q       <= '0;
      cur_idx_q    <= '0;
      mask_q       <= '0;
      cur_cache_q  <= '0;
      cache_vld_q  <= 1'b0;
      k_q          <= '0;
      abort_pend_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      aborted_q    <= 1'b0;
      count_q      <= '0;
      select_q     <= '0;
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_cache_q  <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      cur_idx_q    <= cur_idx_d;
      mask_q       <= mask_d;
      cur_cache_q  <= cur_cache_d;
      cache_vld_q  <= cache_vld_d;
      k_q          <= k_d;
      abort_pend_q <= abort_pend_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      count_q      <= count_d;
      select_q     <= select_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_cache_q  <= out_cache_d;
      out_last_q   <= out_last_d;
    end
  end

  assign ctrl_busy     = busy_q;
  assign ctrl_done     = done_q;
  assign ctrl_aborted  = aborted_q;
  assign ctrl_count    = count_q;
  assign dbg_select    = select_q;
  assign dbg_address   = address_q;
  assign dbg_read      = read_q;
  assign dbg_write     = write_q;
  assign dbg_writedata = writedata_q;
  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign out_cache     = out_cache_q;
  assign out_last      = out_last_q;

endmodule

// File: tb/tb_cache_debug_sweep.sv
// Bench for cache_debug_sweep: modelled debug slaves with waitrequest, random stream backpressure.
module tb_cache_debug_sweep;

  localparam int NC   = 4;
  localparam int IW   = cache_debug_sweep_pkg::INDEX_W;
  localparam int OW   = cache_debug_sweep_pkg::OFFSET_W;
  localparam int NIDX = 1 << IW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            ctrl_start, ctrl_abort;
  logic [IW-1:0]   ctrl_first, ctrl_last;
  logic [NC-1:0]   ctrl_mask;
  logic            ctrl_busy, ctrl_done, ctrl_aborted;
  logic [15:0]     ctrl_count;
  logic [NC-1:0]   dbg_select;
  logic [2:0]      dbg_address;
  logic            dbg_read, dbg_write;
  logic [31:0]     dbg_writedata;
  logic            dbg_waitrequest;
  logic [31:0]     dbg_readdata;
  logic            out_valid, out_ready;
  logic [31:0]     out_data;
  logic [2:0]      out_cache;
  logic            out_last;

  always #5 clk = ~clk;

  cache_debug_sweep #(.NUM_CACHES(NC)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_start(ctrl_start), .ctrl_abort(ctrl_abort),
    .ctrl_first(ctrl_first), .ctrl_last(ctrl_last), .ctrl_mask(ctrl_mask),
    .ctrl_busy(ctrl_busy), .ctrl_done(ctrl_done), .ctrl_aborted(ctrl_aborted), .ctrl_count(ctrl_count),
    .dbg_select(dbg_select), .dbg_address(dbg_address), .dbg_read(dbg_read), .dbg_write(dbg_write),
    .dbg_writedata(dbg_writedata), .dbg_waitrequest(dbg_waitrequest), .dbg_readdata(dbg_readdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cache(out_cache), .out_last(out_last)
  );

  wire [96:0] all_out = {ctrl_busy, ctrl_done, ctrl_aborted, ctrl_count, dbg_select, dbg_address,
                         dbg_read, dbg_write, dbg_writedata, out_valid, out_data, out_cache, out_last};

  int n_checks, n_fails;
  int wait_cycles, ready_pct;
  logic [11:0] salt;

  // Written only by the monitor process
  int          wcnt, n_done, n_writes, n_reads, viol_cnt;
  string       viol_name = "none";
  logic [IW-1:0] slave_idx [NC];
  logic [31:0] last_wdata;
  logic [35:0] cap_q[$];
  logic        prev_wait, prev_stall;
  logic [40:0] prev_bus;
  logic [35:0] prev_out;

  // Written only by the test process
  int          cap_base, done_base, wr_base, rd_base, viol_base;
  logic [35:0] exp_q[$];

  function automatic logic [31:0] line_word(input logic [11:0] s, input int c, input int idx, input logic [2:0] a);
    return {s, 1'b0, 3'(c), 2'b00, 6'(idx), 5'b00000, a};
  endfunction

  // Reference: visit indices first..last (wrapping), masked caches ascending, 5 words per line.
  function automatic void build_expected(input int f, input int l, input logic [NC-1:0] m);
    int idx;
    idx = f;
    exp_q.delete();
    while (1) begin
      for (int c = 0; c < NC; c++) begin
        if (m[c]) begin
          for (int w = 0; w < 5; w++) begin
            logic [2:0] a;
            a = (w == 0) ? 3'd0 : 3'(3 + w);
            exp_q.push_back({(w == 4), 3'(c), line_word(salt, c, idx, a)});
          end
        end
      end
      if (idx == l) break;
      idx = (idx + 1) % NIDX;
    end
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wait = 1'b0; prev_stall = 1'b0; wcnt = 0;
      dbg_waitrequest = 1'b0; out_ready = 1'b0; dbg_readdata = '0;
      foreach (slave_idx[c]) slave_idx[c] = '0;
    end else begin
      int sel_c;
      if (dbg_read && dbg_write) begin viol_cnt++; viol_name = "rd_and_wr"; end
      if ((dbg_read || dbg_write) ? !$onehot(dbg_select) : (dbg_select != '0)) begin
        viol_cnt++; viol_name = "select";
      end
      if (prev_wait && ({dbg_read, dbg_write, dbg_select, dbg_address, dbg_writedata} !== prev_bus)) begin
        viol_cnt++; viol_name = "bus_hold";
      end
      if (prev_stall && ({out_valid, out_last, out_cache, out_data} !== {1'b1, prev_out})) begin
        viol_cnt++; viol_name = "stream_hold";
      end
      if (dbg_write && ((dbg_writedata & ~(32'(NIDX - 1) << OW)) != 32'd0)) begin
        viol_cnt++; viol_name = "wdata_fields";
      end
      if (ctrl_done) n_done++;

      prev_wait = 1'b0;
      if (dbg_read || dbg_write) begin
        if (wcnt < wait_cycles) begin
          wcnt++;
          dbg_waitrequest = 1'b1;
          dbg_readdata = $urandom;
          prev_wait = 1'b1;
          prev_bus = {dbg_read, dbg_write, dbg_select, dbg_address, dbg_writedata};
        end else begin
          wcnt = 0;
          dbg_waitrequest = 1'b0;
          sel_c = 0;
          for (int c = 0; c < NC; c++) if (dbg_select[c]) sel_c = c;
          if (dbg_write) begin
            n_writes++;
            last_wdata = dbg_writedata;
            slave_idx[sel_c] = dbg_writedata[OW +: IW];
          end
          if (dbg_read) begin
            n_reads++;
            dbg_readdata = line_word(salt, sel_c, int'(slave_idx[sel_c]), dbg_address);
          end else begin
            dbg_readdata = $urandom;
          end
        end
      end else begin
        dbg_waitrequest = 1'b0;
        dbg_readdata = $urandom;
      end

      out_ready = (int'($urandom_range(99)) < ready_pct);
      prev_stall = out_valid && !out_ready;
      prev_out = {out_last, out_cache, out_data};
      if (out_valid && out_ready) cap_q.push_back({out_last, out_cache, out_data});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic mark();
    cap_base = cap_q.size(); done_base = n_done; wr_base = n_writes; rd_base = n_reads; viol_base = viol_cnt;
  endtask

  task automatic run_sweep(input logic [IW-1:0] f, input logic [IW-1:0] l, input logic [NC-1:0] m,
                           input bit abort_with_start, input int mid_start, output bit timed_out);
    mark();
    ctrl_first = f; ctrl_last = l; ctrl_mask = m;
    ctrl_start = 1'b1; ctrl_abort = abort_with_start;
    step();
    ctrl_start = 1'b0; ctrl_abort = 1'b0;
    timed_out = 1'b1;
    for (int i = 1; i < 20000; i++) begin
      if (n_done != done_base) begin timed_out = 1'b0; break; end
      if (i == mid_start) begin
        ctrl_first = 6'd9; ctrl_last = 6'd9; ctrl_mask = '1; ctrl_start = 1'b1;
      end else begin
        ctrl_start = 1'b0;
      end
      step();
    end
    ctrl_start = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) step();
    n_checks++;
    if (all_out !== '0) begin n_fails++; $display("FAIL reset_outputs: got %h want 0", all_out); end
    rst_n = 1'b1;
    repeat (2) step();
    n_checks++;
    if (all_out !== '0) begin n_fails++; $display("FAIL idle_outputs: got %h want 0", all_out); end
  endtask

  task automatic test_single();
    bit to;
    wait_cycles = 3; ready_pct = 100; salt = 12'h5A3;
    build_expected(5, 5, 4'b0001);
    run_sweep(6'd5, 6'd5, 4'b0001, 1'b0, 0, to);
    n_checks++; if (to) begin n_fails++; $display("FAIL single_timeout: no done"); end
    n_checks++;
    if (cap_q.size() != cap_base + exp_q.size()) begin
      n_fails++; $display("FAIL single_len: got %0d words want %0d", cap_q.size() - cap_base, exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (cap_q[cap_base + i] !== exp_q[i]) begin n_fails++; $display("FAIL single_word[%0d]: got %h want %h", i, cap_q[cap_base + i], exp_q[i]); end
    end
    n_checks++; if (last_wdata[OW +: IW] !== 6'd5) begin n_fails++; $display("FAIL single_wr_index: got %0d want 5", last_wdata[OW +: IW]); end
    n_checks++; if (ctrl_count !== 16'd1) begin n_fails++; $display("FAIL single_count: got %0d want 1", ctrl_count); end
    n_checks++; if (n_done - done_base != 1) begin n_fails++; $display("FAIL single_done_pulses: got %0d want 1", n_done - done_base); end
    n_checks++; if (ctrl_aborted !== 1'b0) begin n_fails++; $display("FAIL single_aborted: got %b want 0", ctrl_aborted); end
    n_checks++; if (viol_cnt != viol_base) begin n_fails++; $display("FAIL single_protocol: %0d violations, last %s, want 0", viol_cnt - viol_base, viol_name); end
  endtask

  task automatic test_order_busy_start();
    bit to;
    wait_cycles = 1; ready_pct = 100; salt = 12'h3C1;
    build_expected(2, 3, 4'b1010);
    run_sweep(6'd2, 6'd3, 4'b1010, 1'b0, 10, to);
    n_checks++; if (to) begin n_fails++; $display("FAIL order_timeout: no done"); end
    n_checks++;
    if (cap_q.size() != cap_base + exp_q.size()) begin
      n_fails++; $display("FAIL order_len: got %0d words want %0d", cap_q.size() - cap_base, exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (cap_q[cap_base + i] !== exp_q[i]) begin n_fails++; $display("FAIL order_word[%0d]: got %h want %h", i, cap_q[cap_base + i], exp_q[i]); end
    end
    n_checks++; if (ctrl_count !== 16'd4) begin n_fails++; $display("FAIL order_count: got %0d want 4", ctrl_count); end
    n_checks++; if (n_writes - wr_base != 4) begin n_fails++; $display("FAIL order_loads: got %0d want 4", n_writes - wr_base); end
    n_checks++; if (n_done - done_base != 1) begin n_fails++; $display("FAIL order_done_pulses: got %0d want 1", n_done - done_base); end
  endtask

  task automatic test_wrap();
    bit to;
    wait_cycles = 0; ready_pct = 100; salt = 12'h0F7;
    build_expected(NIDX - 1, 1, 4'b0001);
    run_sweep(6'(NIDX - 1), 6'd1, 4'b0001, 1'b0, 0, to);
    n_checks++; if (to) begin n_fails++; $display("FAIL wrap_timeout: no done"); end
    n_checks++;
    if (cap_q.size() != cap_base + exp_q.size()) begin
      n_fails++; $display("FAIL wrap_len: got %0d words want %0d", cap_q.size() - cap_base, exp_q.size());
    end else foreach (exp_q[i]) begin
      n_checks++;
      if (cap_q[cap_base + i] !== exp_q[i]) begin n_fails++; $display("FAIL wrap_word[%0d]: got %h want %h", i, cap_q[cap_base + i], exp_q[i]); end
    end
    n_checks++; if (ctrl_count !== 16'd3) begin n_fails++; $display("FAIL wrap_count: got %0d want 3", ctrl_count); end
  endtask

  task automatic test_backpressure();
    bit to;
    int f, l;
    logic [NC-1:0] m;
    ready_pct = 30;
    for (int rep = 0; rep < 3; rep++) begin
      wait_cycles = $urandom_range(2);
      salt = 12'($urandom);
      m = NC'($urandom_range(15, 1));
      f = $urandom_range(NIDX - 1);
      l = (f + int'($urandom_range(3))) % NIDX;
      build_expected(f, l, m);
      run_sweep(6'(f), 6'(l), m, 1'b0, 0, to);
      n_checks++; if (to) begin n_fails++; $display("FAIL bp_timeout[%0d]: no done", rep); end
      n_checks++;
      if (cap_q.size() != cap_base + exp_q.size()) begin
        n_fails++; $display("FAIL bp_len[%0d]: got %0d words want %0d", rep, cap_q.size() - cap_base, exp_q.size());
      end else foreach (exp_q[i]) begin
        n_checks++;
        if (cap_q[cap_base + i] !== exp_q[i]) begin n_fails++; $display("FAIL bp_word[%0d][%0d]: got %h want %h", rep, i, cap_q[cap_base + i], exp_q[i]); end
      end
      n_checks++; if (ctrl_count !== 16'(exp_q.size() / 5)) begin n_fails++; $display("FAIL bp_count[%0d]: got %0d want %0d", rep, ctrl_count, exp_q.size() / 5); end
      n_checks++; if (viol_cnt != viol_base) begin n_fails++; $display("FAIL bp_protocol[%0d]: %0d violations, last %s, want 0", rep, viol_cnt - viol_base, viol_name); end
    end
  endtask

  task automatic test_abort_load();
    bit seen, got_done;
    wait_cycles = 6; ready_pct = 100; salt = 12'h111;
    mark();
    ctrl_first = 6'd3; ctrl_last = 6'd6; ctrl_mask = '1; ctrl_start = 1'b1;
    step();
    ctrl_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (dbg_write && dbg_waitrequest) seen = 1'b1; else step();
    end
    n_checks++; if (!seen) begin n_fails++; $display("FAIL abort_no_stalled_load: write=%b wait=%b", dbg_write, dbg_waitrequest); end
    ctrl_abort = 1'b1;
    step();
    ctrl_abort = 1'b0;
    n_checks++; if (dbg_write !== 1'b1) begin n_fails++; $display("FAIL abort_write_held: got %b want 1", dbg_write); end
    got_done = 1'b0;
    for (int i = 0; i < 50 && !got_done; i++) begin
      if (n_done != done_base) got_done = 1'b1; else step();
    end
    step();
    n_checks++; if (!got_done) begin n_fails++; $display("FAIL abort_timeout: no done"); end
    n_checks++; if (ctrl_aborted !== 1'b1) begin n_fails++; $display("FAIL abort_flag: got %b want 1", ctrl_aborted); end
    n_checks++; if (ctrl_count !== 16'd0) begin n_fails++; $display("FAIL abort_count: got %0d want 0", ctrl_count); end
    n_checks++; if (n_writes - wr_base != 1) begin n_fails++; $display("FAIL abort_writes: got %0d want 1", n_writes - wr_base); end
    n_checks++; if (n_reads - rd_base != 0) begin n_fails++; $display("FAIL abort_reads: got %0d want 0", n_reads - rd_base); end
    n_checks++; if (viol_cnt != viol_base) begin n_fails++; $display("FAIL abort_protocol: %0d violations, last %s, want 0", viol_cnt - viol_base, viol_name); end
  endtask

  task automatic test_start_abort_same();
    bit to;
    wait_cycles = 0; ready_pct = 100; salt = 12'hABC;
    build_expected(10, 10, 4'b0100);
    run_sweep(6'd10, 6'd10, 4'b0100, 1'b1, 0, to);
    n_checks++; if (to) begin n_fails++; $display("FAIL sa_timeout: no done"); end
    n_checks++; if (ctrl_aborted !== 1'b0) begin n_fails++; $display("FAIL sa_aborted: got %b want 0", ctrl_aborted); end
    n_checks++; if (ctrl_count !== 16'd1) begin n_fails++; $display("FAIL sa_count: got %0d want 1", ctrl_count); end
    n_checks++; if (cap_q.size() - cap_base != exp_q.size()) begin n_fails++; $display("FAIL sa_len: got %0d want %0d", cap_q.size() - cap_base, exp_q.size()); end
  endtask

  task automatic test_mask_zero();
    mark();
    ctrl_first = 6'd0; ctrl_last = 6'd7; ctrl_mask = '0; ctrl_start = 1'b1;
    step();
    ctrl_start = 1'b0;
    n_checks++; if ({ctrl_busy, ctrl_done} !== 2'b10) begin n_fails++; $display("FAIL mz_cycle1: busy,done=%b%b want 10", ctrl_busy, ctrl_done); end
    step();
    n_checks++; if ({ctrl_busy, ctrl_done} !== 2'b11) begin n_fails++; $display("FAIL mz_cycle2: busy,done=%b%b want 11", ctrl_busy, ctrl_done); end
    step();
    n_checks++; if ({ctrl_busy, ctrl_done} !== 2'b00) begin n_fails++; $display("FAIL mz_cycle3: busy,done=%b%b want 00", ctrl_busy, ctrl_done); end
    n_checks++;
    if ((n_writes - wr_base) + (n_reads - rd_base) != 0) begin
      n_fails++; $display("FAIL mz_bus_activity: got %0d transactions want 0", (n_writes - wr_base) + (n_reads - rd_base));
    end
    n_checks++; if (ctrl_count !== 16'd0) begin n_fails++; $display("FAIL mz_count: got %0d want 0", ctrl_count); end
  endtask

  task automatic test_reset_mid_push();
    bit seen;
    int done_snap;
    wait_cycles = 1; ready_pct = 0;
    mark();
    ctrl_first = 6'd7; ctrl_last = 6'd7; ctrl_mask = 4'b0100; ctrl_start = 1'b1;
    step();
    ctrl_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (out_valid) seen = 1'b1; else step();
    end
    n_checks++; if (!seen) begin n_fails++; $display("FAIL rst_no_push: out_valid=%b want 1", out_valid); end
    done_snap = n_done;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (all_out !== '0) begin n_fails++; $display("FAIL rst_outputs: got %h want 0", all_out); end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (3) step();
    n_checks++; if (n_done != done_snap) begin n_fails++; $display("FAIL rst_done_pulse: got %0d pulses want 0", n_done - done_snap); end
    n_checks++; if (all_out !== '0) begin n_fails++; $display("FAIL rst_after_release: got %h want 0", all_out); end
  endtask

  initial begin
    n_checks = 0; n_fails = 0;
    ctrl_start = 1'b0; ctrl_abort = 1'b0; ctrl_first = '0; ctrl_last = '0; ctrl_mask = '0;
    wait_cycles = 0; ready_pct = 100; salt = 12'h5A3;
    n_done = 0; n_writes = 0; n_reads = 0; viol_cnt = 0; wcnt = 0; last_wdata = '0;
    test_reset();
    test_single();
    test_order_busy_start();
    test_wrap();
    test_backpressure();
    test_abort_load();
    test_start_abort_same();
    test_mask_zero();
    test_reset_mid_push();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
